// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK_N = 7'h7F;

  localparam logic [6:0] HEX_SEG_N [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational hex nibble to active-low 7-segment pattern.
// One instance is shared by every digit through the scan index mux.
module hex7seg_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = HEX_SEG_N[nibble];

endmodule

// File: rtl/seg_scan_controller.sv
// Time-multiplexed scan of NUM_DIGITS hex digits onto one active-low segment bus,
// with a blanking gap before each digit and frame-synchronous display updates.
module seg_scan_controller
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int MAX_COUNT = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CW        = $clog2(MAX_COUNT) + 1;
  localparam int IW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW        = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  scan_state_t             state, state_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic [CW-1:0]           counter, counter_nxt;
  logic                    wrap;

  logic [DW-1:0]           staging, staging_nxt;
  logic [NUM_DIGITS-1:0]   staging_dp, staging_dp_nxt;
  logic [DW-1:0]           shadow, shadow_nxt;
  logic [NUM_DIGITS-1:0]   shadow_dp, shadow_dp_nxt;
  logic                    pending, pending_nxt;

  logic [3:0]              cur_nibble;
  logic                    cur_dp;
  logic [6:0]              dec_seg_n;
  logic [6:0]              seg_n_nxt;
  logic                    dp_n_nxt;
  logic [NUM_DIGITS-1:0]   an_n_nxt;

  // Scan sequencing: dropping en forces IDLE from any state, so a re-enable restarts at digit 0.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    counter_nxt = counter;
    wrap        = 1'b0;
    unique case (state)
      IDLE: begin
        if (en) begin
          state_nxt   = BLANK;
          idx_nxt     = '0;
          counter_nxt = '0;
        end
      end
      BLANK: begin
        if (counter == BLANK_LAST) begin
          state_nxt   = SHOW;
          counter_nxt = '0;
        end else begin
          counter_nxt = counter + CW'(1);
        end
      end
      SHOW: begin
        if (counter == SHOW_LAST) begin
          state_nxt   = BLANK;
          counter_nxt = '0;
          if (idx == IDX_LAST) begin
            idx_nxt = '0;
            wrap    = 1'b1;
          end else begin
            idx_nxt = idx + IW'(1);
          end
        end else begin
          counter_nxt = counter + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!en) begin
      state_nxt   = IDLE;
      idx_nxt     = '0;
      counter_nxt = '0;
      wrap        = 1'b0;
    end
  end

  // New data reaches the shadow only while idle or at a frame boundary, so a frame never tears.
  always_comb begin
    staging_nxt    = staging;
    staging_dp_nxt = staging_dp;
    shadow_nxt     = shadow;
    shadow_dp_nxt  = shadow_dp;
    pending_nxt    = pending;
    if (load) begin
      staging_nxt    = digits_in;
      staging_dp_nxt = dp_in;
    end
    if (state == IDLE && load) begin
      shadow_nxt    = digits_in;
      shadow_dp_nxt = dp_in;
      pending_nxt   = 1'b0;
    end else if (wrap) begin
      if (load) begin
        shadow_nxt    = digits_in;
        shadow_dp_nxt = dp_in;
        pending_nxt   = 1'b0;
      end else if (pending) begin
        shadow_nxt    = staging;
        shadow_dp_nxt = staging_dp;
        pending_nxt   = 1'b0;
      end
    end else if (load) begin
      pending_nxt = 1'b1;
    end
  end

  // Outputs are built from next-cycle state so the registered pins line up with the FSM.
  always_comb begin
    cur_nibble = '0;
    cur_dp     = 1'b0;
    an_n_nxt   = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_nxt == IW'(k)) begin
        cur_nibble = shadow_nxt[4*k +: 4];
        cur_dp     = shadow_dp_nxt[k];
        if (state_nxt == SHOW) an_n_nxt[k] = 1'b0;
      end
    end
  end

  hex7seg_decode u_decode (
    .nibble (cur_nibble),
    .seg_n  (dec_seg_n)
  );

  assign seg_n_nxt = (state_nxt == IDLE) ? SEG_BLANK_N : dec_seg_n;
  assign dp_n_nxt  = (state_nxt == IDLE) ? 1'b1 : ~cur_dp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      counter    <= '0;
      staging    <= '0;
      staging_dp <= '0;
      shadow     <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
      seg_n      <= SEG_BLANK_N;
      dp_n       <= 1'b1;
      an_n       <= '1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      counter    <= counter_nxt;
      staging    <= staging_nxt;
      staging_dp <= staging_dp_nxt;
      shadow     <= shadow_nxt;
      shadow_dp  <= shadow_dp_nxt;
      pending    <= pending_nxt;
      seg_n      <= seg_n_nxt;
      dp_n       <= dp_n_nxt;
      an_n       <= an_n_nxt;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Scoreboard bench for seg_scan_controller (4 digits, PRESCALE=4, BLANK_CYCLES=2):
// expected pin states are queued per cycle and a negedge monitor pops and compares them.
module tb_seg_scan_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_done;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int         cyc;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       fd;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  seg_scan_controller #(
    .NUM_DIGITS   (4),
    .PRESCALE     (4),
    .BLANK_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input exp_t e);
    checks++;
    if (seg_n !== e.seg || dp_n !== e.dp || an_n !== e.an || frame_done !== e.fd) begin
      failures++;
      $display("[TB] FAIL %s cyc=%0d got seg_n=%h dp_n=%b an_n=%b frame_done=%b expected seg_n=%h dp_n=%b an_n=%b frame_done=%b",
               e.name, cyc, seg_n, dp_n, an_n, frame_done, e.seg, e.dp, e.an, e.fd);
    end
  endtask

  // Each queued entry is due on exactly one cycle; anything older was skipped and counts as a miss.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      mon_e = sb.pop_front();
      checks++;
      failures++;
      $display("[TB] FAIL %s_missed due_cyc=%0d now_cyc=%0d", mon_e.name, mon_e.cyc, cyc);
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      mon_e = sb.pop_front();
      check_output(mon_e);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic apply_stimulus(input int at, input logic r, input logic e, input logic l,
                                input logic [15:0] d, input logic [3:0] p);
    wait_until(at);
    rst       = r;
    en        = e;
    load      = l;
    digits_in = d;
    dp_in     = p;
  endtask

  task automatic expect_at(input int c, input logic [6:0] s, input logic d, input logic [3:0] a,
                           input logic f, input string nm);
    exp_t e;
    e.cyc  = c;
    e.seg  = s;
    e.dp   = d;
    e.an   = a;
    e.fd   = f;
    e.name = nm;
    sb.push_back(e);
  endtask

  // Digit d of a frame whose base is 'base': blank on base+1+6d..+2, lit on base+3+6d..+6.
  task automatic expect_digit(input int base, input int d, input logic [6:0] s, input logic dpn,
                              input logic fd0, input string nm);
    logic [3:0] an_lit;
    an_lit = ~(4'b0001 << d);
    for (int i = 0; i < 2; i++)
      expect_at(base + 1 + 6*d + i, s, dpn, 4'hF, (i == 0) ? fd0 : 1'b0, $sformatf("%s_d%0d_blank", nm, d));
    for (int i = 0; i < 4; i++)
      expect_at(base + 3 + 6*d + i, s, dpn, an_lit, 1'b0, $sformatf("%s_d%0d_show", nm, d));
  endtask

  task automatic expect_frame(input int base, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dpn,
                              input logic fd0, input string nm);
    expect_digit(base, 0, s0, dpn[0], fd0, nm);
    expect_digit(base, 1, s1, dpn[1], 1'b0, nm);
    expect_digit(base, 2, s2, dpn[2], 1'b0, nm);
    expect_digit(base, 3, s3, dpn[3], 1'b0, nm);
  endtask

  initial begin
    int t, t2, t3;
    rst       = 1'b1;
    en        = 1'b1;
    load      = 1'b0;
    digits_in = 16'h0000;
    dp_in     = 4'b0000;

    wait_until(3);
    expect_at(3, 7'h7F, 1'b1, 4'hF, 1'b0, "reset_hold");
    apply_stimulus(3, 1'b0, 1'b0, 1'b1, 16'h1234, 4'b0000);
    expect_at(4, 7'h7F, 1'b1, 4'hF, 1'b0, "idle_load");
    apply_stimulus(4, 1'b0, 1'b1, 1'b0, 16'h1234, 4'b0000);
    t  = 4;
    t2 = t + 113;
    t3 = t2 + 19;

    expect_frame(t,      7'h19, 7'h30, 7'h24, 7'h79, 4'b1111, 1'b0, "f0_1234");
    expect_frame(t + 24, 7'h19, 7'h30, 7'h24, 7'h79, 4'b1111, 1'b1, "f1_midload");
    expect_frame(t + 48, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 4'b1011, 1'b1, "f2_ffff_dp2");
    expect_frame(t + 72, 7'h00, 7'h46, 7'h12, 7'h08, 4'b1110, 1'b1, "f3_wrapload");
    expect_digit(t + 96, 0, 7'h00, 1'b0, 1'b1, "f4_nopending");
    expect_digit(t + 96, 1, 7'h46, 1'b1, 1'b0, "f4_nopending");
    expect_at(t + 109, 7'h12, 1'b1, 4'hF,    1'b0, "f4_d2_blank");
    expect_at(t + 110, 7'h12, 1'b1, 4'hF,    1'b0, "f4_d2_blank");
    expect_at(t + 111, 7'h12, 1'b1, 4'b1011, 1'b0, "f4_d2_show");
    expect_at(t + 112, 7'h7F, 1'b1, 4'hF,    1'b0, "en_off");
    expect_at(t + 113, 7'h7F, 1'b1, 4'hF,    1'b0, "en_off");
    expect_digit(t2, 0, 7'h00, 1'b0, 1'b0, "resume");
    expect_digit(t2, 1, 7'h46, 1'b1, 1'b0, "resume");
    expect_digit(t2, 2, 7'h12, 1'b1, 1'b0, "resume");
    expect_at(t3, 7'h7F, 1'b1, 4'hF, 1'b0, "rst_mid");
    expect_frame(t3, 7'h40, 7'h40, 7'h40, 7'h40, 4'b1111, 1'b0, "after_rst");
    expect_digit(t3 + 24, 0, 7'h40, 1'b1, 1'b1, "after_rst_wrap");

    apply_stimulus(t + 33,  1'b0, 1'b1, 1'b1, 16'hFFFF, 4'b0100);
    apply_stimulus(t + 34,  1'b0, 1'b1, 1'b0, 16'hFFFF, 4'b0100);
    apply_stimulus(t + 72,  1'b0, 1'b1, 1'b1, 16'hA5C8, 4'b0001);
    apply_stimulus(t + 73,  1'b0, 1'b1, 1'b0, 16'hA5C8, 4'b0001);
    apply_stimulus(t + 111, 1'b0, 1'b0, 1'b0, 16'hA5C8, 4'b0001);
    apply_stimulus(t + 113, 1'b0, 1'b1, 1'b0, 16'hA5C8, 4'b0001);
    apply_stimulus(t2 + 8,  1'b0, 1'b1, 1'b1, 16'h7777, 4'b1111);
    apply_stimulus(t2 + 9,  1'b0, 1'b1, 1'b0, 16'h7777, 4'b1111);
    apply_stimulus(t2 + 18, 1'b1, 1'b1, 1'b0, 16'h7777, 4'b1111);
    apply_stimulus(t2 + 19, 1'b0, 1'b1, 1'b0, 16'h7777, 4'b1111);

    wait_until(t3 + 24 + 6 + 2);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain got %0d pending entries, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
